// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared parameter defaults and lane types for the rename stage
package rename_pkg;

    localparam int RN_WIDTH         = 2;
    localparam int RN_COMMIT_WIDTH  = 2;
    localparam int RN_NUM_ARCH_REGS = 32;
    localparam int RN_NUM_PHYS_REGS = 64;
    localparam int RN_AW            = $clog2(RN_NUM_ARCH_REGS);
    localparam int RN_PW            = $clog2(RN_NUM_PHYS_REGS);

    typedef logic [RN_AW-1:0] areg_t;
    typedef logic [RN_PW-1:0] preg_t;

    typedef struct packed {
        logic  valid;
        areg_t rs1;
        areg_t rs2;
        areg_t rd;
    } rename_lane_t;

    typedef struct packed {
        logic  valid;
        preg_t p_rs1;
        preg_t p_rs2;
        preg_t p_rd;
        preg_t p_old_rd;
    } renamed_lane_t;

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - physical register free bitvector with lowest-first pick
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   alloc_mask      registers handed out this cycle (cleared)
//   release_mask    registers reclaimed at commit this cycle (set)
//   rebuild         replace the whole vector with rebuild_mask (flush recovery)
//   rebuild_mask    free vector recomputed from the retirement RAT
//   pick            WIDTH lowest-indexed free registers, slot 0 lowest
//   free_count      popcount of the registered free vector
module rename_free_list
    import rename_pkg::*;
#(
    parameter int NUM_PHYS_REGS = RN_NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS = RN_NUM_ARCH_REGS,
    parameter int WIDTH         = RN_WIDTH,
    localparam int PW           = $clog2(NUM_PHYS_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PHYS_REGS-1:0] alloc_mask,
    input  logic [NUM_PHYS_REGS-1:0] release_mask,
    input  logic                     rebuild,
    input  logic [NUM_PHYS_REGS-1:0] rebuild_mask,
    output logic [WIDTH*PW-1:0]      pick,
    output logic [PW:0]              free_count
);

    localparam logic [NUM_PHYS_REGS-1:0] RESET_MASK =
        {{(NUM_PHYS_REGS-NUM_ARCH_REGS){1'b1}}, {NUM_ARCH_REGS{1'b0}}};

    logic [NUM_PHYS_REGS-1:0] free_q;
    logic [NUM_PHYS_REGS-1:0] free_d;

    always_comb begin
        if (rebuild) begin
            free_d = rebuild_mask;
        end else begin
            free_d = (free_q & ~alloc_mask) | release_mask;
        end
        // p0 backs x0 and must never become allocatable
        free_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_q <= RESET_MASK;
        end else begin
            free_q <= free_d;
        end
    end

    // Picks come from registered state only, so a register released this
    // cycle is first offered on the next one.
    always_comb begin
        int found;
        found = 0;
        pick  = '0;
        for (int p = 0; p < NUM_PHYS_REGS; p++) begin
            if (free_q[p] && found < WIDTH) begin
                pick[found*PW +: PW] = PW'(p);
                found = found + 1;
            end
        end
    end

    always_comb begin
        free_count = '0;
        for (int p = 0; p < NUM_PHYS_REGS; p++) begin
            free_count = free_count + (PW+1)'(free_q[p]);
        end
    end

endmodule

// File: rtl/rename_unit.sv
// rtl/rename_unit.sv - N-wide register rename stage with commit reclaim and flush recovery
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   in_valid/in_ready                   rename group handshake from decode
//   in_lane_valid, in_rs1/rs2/rd        per-lane architectural operands, lane 0 oldest
//   out_valid/out_ready                 renamed group handshake to dispatch
//   out_lane_valid, out_p_*             per-lane physical operands (registered)
//   commit_valid, commit_rd/p_rd/p_old_rd   retirement ports, index order
//   flush                               restore speculative state from retirement state
//   free_count                          number of free physical registers
// Optional: RENAME_PERF_CNT_EN adds perf_stall_free / perf_stall_bp stall counters.
module rename_unit
    import rename_pkg::*;
#(
    parameter int WIDTH         = RN_WIDTH,
    parameter int COMMIT_WIDTH  = RN_COMMIT_WIDTH,
    parameter int NUM_ARCH_REGS = RN_NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS = RN_NUM_PHYS_REGS,
    localparam int AW           = $clog2(NUM_ARCH_REGS),
    localparam int PW           = $clog2(NUM_PHYS_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_lane_valid,
    input  logic [WIDTH*AW-1:0]        in_rs1,
    input  logic [WIDTH*AW-1:0]        in_rs2,
    input  logic [WIDTH*AW-1:0]        in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_lane_valid,
    output logic [WIDTH*PW-1:0]        out_p_rs1,
    output logic [WIDTH*PW-1:0]        out_p_rs2,
    output logic [WIDTH*PW-1:0]        out_p_rd,
    output logic [WIDTH*PW-1:0]        out_p_old_rd,
    input  logic [COMMIT_WIDTH-1:0]    commit_valid,
    input  logic [COMMIT_WIDTH*AW-1:0] commit_rd,
    input  logic [COMMIT_WIDTH*PW-1:0] commit_p_rd,
    input  logic [COMMIT_WIDTH*PW-1:0] commit_p_old_rd,
    input  logic                       flush,
    output logic [PW:0]                free_count
`ifdef RENAME_PERF_CNT_EN
    ,
    output logic [31:0]                perf_stall_free,
    output logic [31:0]                perf_stall_bp
`endif
);

    logic [PW-1:0] spec_rat_q   [NUM_ARCH_REGS];
    logic [PW-1:0] spec_rat_d   [NUM_ARCH_REGS];
    logic [PW-1:0] retire_rat_q [NUM_ARCH_REGS];
    logic [PW-1:0] retire_rat_d [NUM_ARCH_REGS];

    logic                out_valid_q,      out_valid_d;
    logic [WIDTH-1:0]    out_lane_valid_q, out_lane_valid_d;
    logic [WIDTH*PW-1:0] out_p_rs1_q,      out_p_rs1_d;
    logic [WIDTH*PW-1:0] out_p_rs2_q,      out_p_rs2_d;
    logic [WIDTH*PW-1:0] out_p_rd_q,       out_p_rd_d;
    logic [WIDTH*PW-1:0] out_p_old_rd_q,   out_p_old_rd_d;

    logic [NUM_PHYS_REGS-1:0] alloc_mask, release_mask, rebuild_mask;
    logic [WIDTH*PW-1:0]      fl_pick;
    logic [PW:0]              fl_count;
    logic                     accept;

    logic [PW-1:0] ren_rs1 [WIDTH];
    logic [PW-1:0] ren_rs2 [WIDTH];
    logic [PW-1:0] ren_rd  [WIDTH];
    logic [PW-1:0] ren_old [WIDTH];

    rename_free_list #(
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .NUM_ARCH_REGS (NUM_ARCH_REGS),
        .WIDTH         (WIDTH)
    ) u_free_list (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_mask   (alloc_mask),
        .release_mask (release_mask),
        .rebuild      (flush),
        .rebuild_mask (rebuild_mask),
        .pick         (fl_pick),
        .free_count   (fl_count)
    );

    // Requires WIDTH free registers regardless of how many lanes write,
    // which keeps the ready path independent of the lane contents.
    assign in_ready   = !flush && (fl_count >= (PW+1)'(WIDTH)) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign free_count = fl_count;

    // Rename: lookup in the spec RAT, then override with the youngest older
    // lane of this group that writes the same nonzero arch register.
    always_comb begin
        int            n_alloc;
        logic [AW-1:0] a_rs1, a_rs2, a_rd, k_rd;
        logic [PW-1:0] prd [WIDTH];
        n_alloc = 0;
        a_rs1   = '0;
        a_rs2   = '0;
        a_rd    = '0;
        k_rd    = '0;
        for (int j = 0; j < WIDTH; j++) begin
            prd[j] = '0;
        end
        for (int j = 0; j < WIDTH; j++) begin
            a_rs1      = in_rs1[j*AW +: AW];
            a_rs2      = in_rs2[j*AW +: AW];
            a_rd       = in_rd[j*AW +: AW];
            ren_rs1[j] = (a_rs1 == '0) ? '0 : spec_rat_q[a_rs1];
            ren_rs2[j] = (a_rs2 == '0) ? '0 : spec_rat_q[a_rs2];
            ren_old[j] = (a_rd  == '0) ? '0 : spec_rat_q[a_rd];
            for (int k = 0; k < j; k++) begin
                k_rd = in_rd[k*AW +: AW];
                if (in_lane_valid[k] && k_rd != '0) begin
                    if (k_rd == a_rs1) ren_rs1[j] = prd[k];
                    if (k_rd == a_rs2) ren_rs2[j] = prd[k];
                    if (k_rd == a_rd)  ren_old[j] = prd[k];
                end
            end
            if (in_lane_valid[j] && a_rd != '0) begin
                prd[j]  = fl_pick[n_alloc*PW +: PW];
                n_alloc = n_alloc + 1;
            end
        end
        for (int j = 0; j < WIDTH; j++) begin
            ren_rd[j] = prd[j];
        end
    end

    always_comb begin
        logic [AW-1:0] c_rd, l_rd;
        c_rd             = '0;
        l_rd             = '0;
        retire_rat_d     = retire_rat_q;
        spec_rat_d       = spec_rat_q;
        alloc_mask       = '0;
        release_mask     = '0;
        rebuild_mask     = '1;
        out_valid_d      = out_valid_q && !out_ready;
        out_lane_valid_d = out_lane_valid_q;
        out_p_rs1_d      = out_p_rs1_q;
        out_p_rs2_d      = out_p_rs2_q;
        out_p_rd_d       = out_p_rd_q;
        out_p_old_rd_d   = out_p_old_rd_q;

        // Higher commit ports are applied later and so win on a shared rd.
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            c_rd = commit_rd[c*AW +: AW];
            if (commit_valid[c] && c_rd != '0) begin
                retire_rat_d[c_rd] = commit_p_rd[c*PW +: PW];
                release_mask[commit_p_old_rd[c*PW +: PW]] = 1'b1;
            end
        end

        // Everything the post-commit retirement RAT does not reference is free.
        for (int a = 0; a < NUM_ARCH_REGS; a++) begin
            rebuild_mask[retire_rat_d[a]] = 1'b0;
        end
        rebuild_mask[0] = 1'b0;

        if (flush) begin
            spec_rat_d  = retire_rat_d;
            out_valid_d = 1'b0;
        end else if (accept) begin
            for (int j = 0; j < WIDTH; j++) begin
                l_rd = in_rd[j*AW +: AW];
                if (in_lane_valid[j] && l_rd != '0) begin
                    spec_rat_d[l_rd]      = ren_rd[j];
                    alloc_mask[ren_rd[j]] = 1'b1;
                end
                out_p_rs1_d[j*PW +: PW]    = in_lane_valid[j] ? ren_rs1[j] : '0;
                out_p_rs2_d[j*PW +: PW]    = in_lane_valid[j] ? ren_rs2[j] : '0;
                out_p_rd_d[j*PW +: PW]     = in_lane_valid[j] ? ren_rd[j]  : '0;
                out_p_old_rd_d[j*PW +: PW] = in_lane_valid[j] ? ren_old[j] : '0;
            end
            out_valid_d      = 1'b1;
            out_lane_valid_d = in_lane_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                spec_rat_q[i]   <= PW'(i);
                retire_rat_q[i] <= PW'(i);
            end
            out_valid_q      <= 1'b0;
            out_lane_valid_q <= '0;
            out_p_rs1_q      <= '0;
            out_p_rs2_q      <= '0;
            out_p_rd_q       <= '0;
            out_p_old_rd_q   <= '0;
        end else begin
            spec_rat_q       <= spec_rat_d;
            retire_rat_q     <= retire_rat_d;
            out_valid_q      <= out_valid_d;
            out_lane_valid_q <= out_lane_valid_d;
            out_p_rs1_q      <= out_p_rs1_d;
            out_p_rs2_q      <= out_p_rs2_d;
            out_p_rd_q       <= out_p_rd_d;
            out_p_old_rd_q   <= out_p_old_rd_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_lane_valid = out_lane_valid_q;
    assign out_p_rs1      = out_p_rs1_q;
    assign out_p_rs2      = out_p_rs2_q;
    assign out_p_rd       = out_p_rd_q;
    assign out_p_old_rd   = out_p_old_rd_q;

`ifdef RENAME_PERF_CNT_EN
    logic [31:0] perf_stall_free_q, perf_stall_free_d;
    logic [31:0] perf_stall_bp_q,   perf_stall_bp_d;

    // Saturating; deliberately untouched by flush.
    always_comb begin
        perf_stall_free_d = perf_stall_free_q;
        perf_stall_bp_d   = perf_stall_bp_q;
        if (in_valid && fl_count < (PW+1)'(WIDTH) && perf_stall_free_q != '1) begin
            perf_stall_free_d = perf_stall_free_q + 32'd1;
        end
        if (in_valid && out_valid_q && !out_ready && perf_stall_bp_q != '1) begin
            perf_stall_bp_d = perf_stall_bp_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_free_q <= '0;
            perf_stall_bp_q   <= '0;
        end else begin
            perf_stall_free_q <= perf_stall_free_d;
            perf_stall_bp_q   <= perf_stall_bp_d;
        end
    end

    assign perf_stall_free = perf_stall_free_q;
    assign perf_stall_bp   = perf_stall_bp_q;
`endif

endmodule

// File: tb/tb_rename_unit.sv
// tb/tb_rename_unit.sv - self-checking bench for rename_unit with a behavioural model
module tb_rename_unit;
    import rename_pkg::*;

    localparam int W  = RN_WIDTH;
    localparam int CW = RN_COMMIT_WIDTH;
    localparam int NA = RN_NUM_ARCH_REGS;
    localparam int NP = RN_NUM_PHYS_REGS;
    localparam int AW = RN_AW;
    localparam int PW = RN_PW;

    typedef struct {
        int rd;
        int p_rd;
        int p_old;
    } inflight_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid, in_ready;
    logic [W-1:0]      in_lane_valid;
    logic [W*AW-1:0]   in_rs1, in_rs2, in_rd;
    logic              out_valid, out_ready;
    logic [W-1:0]      out_lane_valid;
    logic [W*PW-1:0]   out_p_rs1, out_p_rs2, out_p_rd, out_p_old_rd;
    logic [CW-1:0]     commit_valid;
    logic [CW*AW-1:0]  commit_rd;
    logic [CW*PW-1:0]  commit_p_rd, commit_p_old_rd;
    logic              flush;
    logic [PW:0]       free_count;

    rename_lane_t lin [W];
    logic         c_v    [CW];
    int           c_rd   [CW];
    int           c_prd  [CW];
    int           c_pold [CW];

    always_comb begin
        in_lane_valid   = '0;
        in_rs1          = '0;
        in_rs2          = '0;
        in_rd           = '0;
        commit_valid    = '0;
        commit_rd       = '0;
        commit_p_rd     = '0;
        commit_p_old_rd = '0;
        for (int j = 0; j < W; j++) begin
            in_lane_valid[j]    = lin[j].valid;
            in_rs1[j*AW +: AW]  = lin[j].rs1;
            in_rs2[j*AW +: AW]  = lin[j].rs2;
            in_rd[j*AW +: AW]   = lin[j].rd;
        end
        for (int c = 0; c < CW; c++) begin
            commit_valid[c]             = c_v[c];
            commit_rd[c*AW +: AW]       = AW'(c_rd[c]);
            commit_p_rd[c*PW +: PW]     = PW'(c_prd[c]);
            commit_p_old_rd[c*PW +: PW] = PW'(c_pold[c]);
        end
    end

    rename_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_lane_valid   (in_lane_valid),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rd           (in_rd),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_lane_valid  (out_lane_valid),
        .out_p_rs1       (out_p_rs1),
        .out_p_rs2       (out_p_rs2),
        .out_p_rd        (out_p_rd),
        .out_p_old_rd    (out_p_old_rd),
        .commit_valid    (commit_valid),
        .commit_rd       (commit_rd),
        .commit_p_rd     (commit_p_rd),
        .commit_p_old_rd (commit_p_old_rd),
        .flush           (flush),
        .free_count      (free_count)
    );

    // Reference state
    int            m_spec [NA];
    int            m_ret  [NA];
    bit            m_free [NP];
    bit            m_ov;
    renamed_lane_t m_out  [W];
    inflight_t     inflight [$];

    int n_vec = 0;
    int n_err = 0;

    function automatic int m_fc();
        int n = 0;
        for (int p = 0; p < NP; p++) n += int'(m_free[p]);
        return n;
    endfunction

    function automatic bit m_rdy();
        return !flush && (m_fc() >= W) && (!m_ov || out_ready);
    endfunction

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int j = 0; j < W; j++) lin[j] = '0;
        for (int c = 0; c < CW; c++) begin
            c_v[c] = 1'b0; c_rd[c] = 0; c_prd[c] = 0; c_pold[c] = 0;
        end
    endtask

    task automatic set_lane(input int j, input bit v, input int rs1, input int rs2, input int rd);
        lin[j].valid = v;
        lin[j].rs1   = areg_t'(rs1);
        lin[j].rs2   = areg_t'(rs2);
        lin[j].rd    = areg_t'(rd);
    endtask

    // Advances one clock; the model consumes the inputs held across the edge.
    task automatic tick();
        int            spec_n [NA];
        int            ret_n  [NA];
        bit            free_n [NP];
        renamed_lane_t grp    [W];
        int            picks  [$];
        bit            acc, ov_n;
        int            v;
        if (!rst_n) begin
            @(posedge clk);
            #1;
            for (int a = 0; a < NA; a++) begin m_spec[a] = a; m_ret[a] = a; end
            for (int p = 0; p < NP; p++) m_free[p] = (p >= NA);
            m_ov = 1'b0;
            for (int j = 0; j < W; j++) m_out[j] = '0;
            inflight.delete();
            return;
        end
        acc    = in_valid && m_rdy();
        spec_n = m_spec;
        ret_n  = m_ret;
        free_n = m_free;
        ov_n   = m_ov && !out_ready;
        for (int j = 0; j < W; j++) grp[j] = '0;
        if (acc) begin
            for (int p = 1; p < NP; p++) if (m_free[p]) picks.push_back(p);
            for (int j = 0; j < W; j++) begin
                if (lin[j].valid) begin
                    grp[j].valid = 1'b1;
                    v = (lin[j].rs1 == 0) ? 0 : m_spec[lin[j].rs1];
                    for (int k = j - 1; k >= 0; k--) if (grp[k].p_rd != 0 && lin[k].rd == lin[j].rs1) begin v = grp[k].p_rd; break; end
                    grp[j].p_rs1 = preg_t'(v);
                    v = (lin[j].rs2 == 0) ? 0 : m_spec[lin[j].rs2];
                    for (int k = j - 1; k >= 0; k--) if (grp[k].p_rd != 0 && lin[k].rd == lin[j].rs2) begin v = grp[k].p_rd; break; end
                    grp[j].p_rs2 = preg_t'(v);
                    v = (lin[j].rd == 0) ? 0 : m_spec[lin[j].rd];
                    for (int k = j - 1; k >= 0; k--) if (grp[k].p_rd != 0 && lin[k].rd == lin[j].rd) begin v = grp[k].p_rd; break; end
                    grp[j].p_old_rd = preg_t'(v);
                    if (lin[j].rd != 0) grp[j].p_rd = preg_t'(picks.pop_front());
                end
            end
        end
        for (int c = 0; c < CW; c++) begin
            if (c_v[c] && c_rd[c] != 0) begin
                ret_n[c_rd[c]] = c_prd[c];
                if (c_pold[c] != 0) free_n[c_pold[c]] = 1'b1;
            end
        end
        if (flush) begin
            spec_n = ret_n;
            for (int p = 0; p < NP; p++) free_n[p] = 1'b1;
            for (int a = 0; a < NA; a++) free_n[ret_n[a]] = 1'b0;
            free_n[0] = 1'b0;
            ov_n = 1'b0;
            inflight.delete();
        end else if (acc) begin
            for (int j = 0; j < W; j++) begin
                if (grp[j].p_rd != 0) begin
                    spec_n[lin[j].rd] = grp[j].p_rd;
                    free_n[grp[j].p_rd] = 1'b0;
                end
                if (grp[j].valid) inflight.push_back('{int'(lin[j].rd), int'(grp[j].p_rd), int'(grp[j].p_old_rd)});
            end
            m_out = grp;
            ov_n  = 1'b1;
        end
        @(posedge clk);
        #1;
        m_spec = spec_n;
        m_ret  = ret_n;
        m_free = free_n;
        m_ov   = ov_n;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_vec++; if (free_count !== 7'(32)) begin n_err++; $display("FAIL reset_free_count: got %0d want 32", free_count); end
        n_vec++; if (out_p_rd !== '0 || out_p_old_rd !== '0 || out_p_rs1 !== '0 || out_p_rs2 !== '0 || out_lane_valid !== '0) begin
            n_err++; $display("FAIL reset_out_zero: got rd=%h old=%h rs1=%h rs2=%h lv=%b want all 0", out_p_rd, out_p_old_rd, out_p_rs1, out_p_rs2, out_lane_valid);
        end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        // reset while a group is held
        in_valid = 1'b1; out_ready = 1'b0;
        set_lane(0, 1, 1, 2, 5); set_lane(1, 1, 3, 4, 6);
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midreset_pre_valid: got %0b want 1", out_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        n_vec++; if (out_valid !== 1'b0 || free_count !== 7'(32)) begin
            n_err++; $display("FAIL midreset_state: got valid=%0b free=%0d want valid=0 free=32", out_valid, free_count);
        end
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = 1'b1;
        set_lane(0, 1, 1, 2, 5); set_lane(1, 1, 7, 0, 6);
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got out_valid=%0b want 1", out_valid); end
        n_vec++; if (out_p_rd !== {6'd33, 6'd32}) begin n_err++; $display("FAIL basic_p_rd: got %h want {33,32}", out_p_rd); end
        n_vec++; if (out_p_old_rd !== {6'd6, 6'd5}) begin n_err++; $display("FAIL basic_old_rd: got %h want {6,5}", out_p_old_rd); end
        n_vec++; if (out_p_rs1 !== {6'd7, 6'd1} || out_p_rs2 !== {6'd0, 6'd2}) begin
            n_err++; $display("FAIL basic_srcs: got rs1=%h rs2=%h want rs1={7,1} rs2={0,2}", out_p_rs1, out_p_rs2);
        end
        n_vec++; if (free_count !== 7'(30)) begin n_err++; $display("FAIL basic_free_count: got %0d want 30", free_count); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got out_valid=%0b want 0", out_valid); end
    endtask

    task automatic test_forward();
        do_reset();
        in_valid = 1'b1;
        set_lane(0, 1, 1, 2, 3); set_lane(1, 1, 3, 0, 3);
        tick();
        n_vec++; if (out_p_rs1[PW +: PW] !== 6'd32 || out_p_old_rd[PW +: PW] !== 6'd32 || out_p_rd[PW +: PW] !== 6'd33) begin
            n_err++; $display("FAIL fwd_lane1: got rs1=%0d old=%0d rd=%0d want 32 32 33", out_p_rs1[PW +: PW], out_p_old_rd[PW +: PW], out_p_rd[PW +: PW]);
        end
        set_lane(0, 1, 3, 0, 0); set_lane(1, 0, 3, 3, 3);
        tick();
        idle();
        n_vec++; if (out_p_rs1[0 +: PW] !== 6'd33) begin n_err++; $display("FAIL fwd_spec_rat3: got %0d want 33", out_p_rs1[0 +: PW]); end
        n_vec++; if (out_lane_valid !== 2'b01 || out_p_rd !== '0 || out_p_rs1[PW +: PW] !== 6'd0) begin
            n_err++; $display("FAIL fwd_partial_group: got lv=%b rd=%h rs1_1=%0d want lv=01 rd=0 rs1_1=0", out_lane_valid, out_p_rd, out_p_rs1[PW +: PW]);
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        in_valid = 1'b1;
        for (int g = 0; g < 15; g++) begin
            set_lane(0, 1, 0, 0, 1 + g); set_lane(1, 1, 0, 0, 16 + g);
            tick();
        end
        n_vec++; if (free_count !== 7'(2)) begin n_err++; $display("FAIL exh_free2: got %0d want 2", free_count); end
        set_lane(0, 1, 0, 0, 1); set_lane(1, 1, 0, 0, 0);
        tick();
        n_vec++; if (out_p_rd[0 +: PW] !== 6'd62 || free_count !== 7'(1)) begin
            n_err++; $display("FAIL exh_last: got p_rd=%0d free=%0d want 62 1", out_p_rd[0 +: PW], free_count);
        end
        set_lane(0, 1, 0, 0, 2); set_lane(1, 0, 0, 0, 0);
        c_v[0] = 1'b1; c_rd[0] = 7; c_prd[0] = 38; c_pold[0] = 7;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL exh_not_ready: got %0b want 0", in_ready); end
        tick();
        c_v[0] = 1'b0;
        #1;
        n_vec++; if (free_count !== 7'(2) || in_ready !== 1'b1) begin
            n_err++; $display("FAIL exh_freed: got free=%0d ready=%0b want 2 1", free_count, in_ready);
        end
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b1 || out_p_rd[0 +: PW] !== 6'd7) begin
            n_err++; $display("FAIL exh_realloc_p7: got valid=%0b p_rd=%0d want 1 7", out_valid, out_p_rd[0 +: PW]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        set_lane(0, 1, 1, 2, 5); set_lane(1, 1, 3, 4, 6);
        tick();
        set_lane(0, 1, 5, 6, 7); set_lane(1, 1, 0, 0, 8);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d: got %0b want 0", i, in_ready); end
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_p_rd !== {6'd33, 6'd32} || out_p_old_rd !== {6'd6, 6'd5} || out_p_rs1 !== {6'd3, 6'd1}) begin
                n_err++; $display("FAIL bp_hold%0d: got v=%0b rd=%h old=%h rs1=%h want 1 {33,32} {6,5} {3,1}", i, out_valid, out_p_rd, out_p_old_rd, out_p_rs1);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        tick();
        idle();
        n_vec++; if (out_p_rd !== {6'd35, 6'd34} || out_p_rs1 !== {6'd0, 6'd32} || out_p_rs2 !== {6'd0, 6'd33} || free_count !== 7'(28)) begin
            n_err++; $display("FAIL bp_second: got rd=%h rs1=%h rs2=%h free=%0d want {35,34} {0,32} {0,33} 28", out_p_rd, out_p_rs1, out_p_rs2, free_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        set_lane(0, 1, 0, 0, 4); set_lane(1, 1, 0, 0, 9);
        tick();
        idle();
        c_v[0] = 1'b1; c_rd[0] = 4; c_prd[0] = 32; c_pold[0] = 4;
        tick();
        idle();
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        set_lane(0, 1, 9, 4, 10); set_lane(1, 1, 0, 0, 11);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_blocks_accept: got %0b want 0", in_ready); end
        tick();
        flush = 1'b0;
        n_vec++; if (free_count !== 7'(32) || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_state: got free=%0d valid=%0b want 32 0", free_count, out_valid);
        end
        out_ready = 1'b1;
        tick();
        idle();
        n_vec++; if (out_p_rs1[0 +: PW] !== 6'd9 || out_p_rs2[0 +: PW] !== 6'd32) begin
            n_err++; $display("FAIL flush_rat: got rat9=%0d rat4=%0d want 9 32", out_p_rs1[0 +: PW], out_p_rs2[0 +: PW]);
        end
        n_vec++; if (out_p_rd !== {6'd33, 6'd4}) begin n_err++; $display("FAIL flush_freed_regs: got %h want {33,4}", out_p_rd); end
    endtask

    task automatic test_rd_zero();
        do_reset();
        in_valid = 1'b1;
        set_lane(0, 1, 3, 0, 0); set_lane(1, 1, 0, 5, 0);
        c_v[0] = 1'b1; c_rd[0] = 3; c_prd[0] = 3; c_pold[0] = 0;
        c_v[1] = 1'b1; c_rd[1] = 0; c_prd[1] = 0; c_pold[1] = 5;
        tick();
        idle();
        n_vec++; if (out_p_rd !== '0 || free_count !== 7'(32)) begin
            n_err++; $display("FAIL rd0_no_alloc: got rd=%h free=%0d want 0 32", out_p_rd, free_count);
        end
        n_vec++; if (out_p_rs1 !== {6'd0, 6'd3} || out_p_rs2 !== {6'd5, 6'd0}) begin
            n_err++; $display("FAIL rd0_srcs: got rs1=%h rs2=%h want {0,3} {5,0}", out_p_rs1, out_p_rs2);
        end
    endtask

    task automatic test_random();
        int ncmt;
        do_reset();
        for (int it = 0; it < 600; it++) begin
            idle();
            rst_n     = (it != 300);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 4);
            for (int j = 0; j < W; j++) begin
                set_lane(j, ($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end
            ncmt = $urandom_range(0, CW);
            if (ncmt > inflight.size()) ncmt = inflight.size();
            for (int c = 0; c < ncmt; c++) begin
                c_v[c] = 1'b1; c_rd[c] = inflight[0].rd; c_prd[c] = inflight[0].p_rd; c_pold[c] = inflight[0].p_old;
                void'(inflight.pop_front());
            end
            #1;
            n_vec++; if (in_ready !== m_rdy()) begin n_err++; $display("FAIL rnd_in_ready@%0d: got %0b want %0b", it, in_ready, m_rdy()); end
            tick();
            n_vec++; if (out_valid !== m_ov) begin n_err++; $display("FAIL rnd_out_valid@%0d: got %0b want %0b", it, out_valid, m_ov); end
            n_vec++; if (free_count !== (PW+1)'(m_fc())) begin n_err++; $display("FAIL rnd_free_count@%0d: got %0d want %0d", it, free_count, m_fc()); end
            if (m_ov) begin
                for (int j = 0; j < W; j++) begin
                    n_vec++;
                    if (out_lane_valid[j] !== m_out[j].valid || out_p_rs1[j*PW +: PW] !== m_out[j].p_rs1 ||
                        out_p_rs2[j*PW +: PW] !== m_out[j].p_rs2 || out_p_rd[j*PW +: PW] !== m_out[j].p_rd ||
                        out_p_old_rd[j*PW +: PW] !== m_out[j].p_old_rd) begin
                        n_err++;
                        $display("FAIL rnd_lane%0d@%0d: got v=%0b rs1=%0d rs2=%0d rd=%0d old=%0d want v=%0b rs1=%0d rs2=%0d rd=%0d old=%0d",
                                 j, it, out_lane_valid[j], out_p_rs1[j*PW +: PW], out_p_rs2[j*PW +: PW], out_p_rd[j*PW +: PW], out_p_old_rd[j*PW +: PW],
                                 m_out[j].valid, m_out[j].p_rs1, m_out[j].p_rs2, m_out[j].p_rd, m_out[j].p_old_rd);
                    end
                end
            end
        end
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_forward();
        test_exhaust();
        test_back_to_back();
        test_flush();
        test_rd_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Parametrised N-wide register-rename stage. Holds its own speculative RAT, retirement RAT and physical free list.
- Sits between decode and dispatch. Renames up to WIDTH instructions per cycle behind a valid/ready handshake.
- Reclaims old physical registers at commit. Restores speculative state on flush.
- Successor to the fixed 2-wide rename stage: generalised lane count and register counts, plus backpressure, commit-time freeing and flush recovery.

Parameters:
- WIDTH, 2, rename lanes per group.
- COMMIT_WIDTH, 2, commit ports per cycle.
- NUM_ARCH_REGS, 32, architectural registers; x0 is hardwired to p0.
- NUM_PHYS_REGS, 64, physical registers; must be > NUM_ARCH_REGS + WIDTH.
- Derived: AW = $clog2(NUM_ARCH_REGS), PW = $clog2(NUM_PHYS_REGS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  rename group offered.
- in_ready  out  1  group accepted when in_valid && in_ready.
- in_lane_valid  in  WIDTH  per-lane instruction present.
- in_rs1/in_rs2/in_rd  in  WIDTH x AW  architectural operands, lane 0 oldest.
- out_valid  out  1  renamed group available.
- out_ready  in  1  dispatch accepts group.
- out_lane_valid  out  WIDTH  copy of the accepted lane valids.
- out_p_rs1/out_p_rs2/out_p_rd/out_p_old_rd  out  WIDTH x PW  renamed operands.
- commit_valid  in  COMMIT_WIDTH  per-port commit strobe.
- commit_rd  in  COMMIT_WIDTH x AW.
- commit_p_rd/commit_p_old_rd  in  COMMIT_WIDTH x PW.
- flush  in  1  mispredict/exception recovery.
- free_count  out  PW+1  number of set free-list bits.

Behaviour:
- Reset (rst_n=0 at posedge):
  - Both RATs: entry i = i.
  - Free list: bits 0..NUM_ARCH_REGS-1 clear, remaining bits set.
  - out_valid=0; all out_* = 0.
  - free_count = NUM_PHYS_REGS - NUM_ARCH_REGS.
- Reset mid-operation discards any held group and all pending state.
- in_ready (combinational) = !flush && free_count >= WIDTH && (!out_valid || out_ready).
  - The WIDTH-free check is deliberately conservative; it does not depend on how many lanes write.
- Allocation on accept:
  - Lanes with lane_valid && rd != 0 take the lowest-indexed free registers, in lane order (lowest to lane 0).
  - Lanes that do not allocate get p_rd = 0.
  - p0 is never allocated and never freed.
- Intra-group forwarding:
  - Lane j source rsX maps to the p_rd of the youngest older lane k<j writing the same nonzero arch reg; otherwise to spec RAT.
  - p_old_rd follows the same rule.
  - rs = 0 always maps to p0.
- Spec RAT update: youngest writer in the group wins per arch reg. Allocated bits are cleared in the free list.
- Latency: outputs are registered, 1 cycle after accept.
- Output hold: out_* stay stable while out_valid && !out_ready. Back-to-back accept is allowed when out_ready=1.
- Commit, each valid port with rd != 0:
  - retire RAT[rd] <= p_rd.
  - Free bit p_old_rd <= 1, unless p_old_rd = 0.
  - Ports are applied in index order; a higher index wins on the same rd.
- Commit and accept in the same cycle:
  - Both take effect.
  - Registers freed that cycle are allocatable from the next cycle only, because allocation reads registered state.
- Flush (has priority over accept):
  - Same-cycle commits are applied to the retire RAT first.
  - spec RAT <= updated retire RAT.
  - Free list <= 1 for every p not referenced by the updated retire RAT; p0 stays clear.
  - out_valid <= 0.
- free_count reflects registered state only.

Optional Feature:
- Macro RENAME_PERF_CNT_EN.
- Defined: adds two outputs, perf_stall_free (32) and perf_stall_bp (32).
  - perf_stall_free counts cycles with in_valid && free_count < WIDTH.
  - perf_stall_bp counts cycles with in_valid && out_valid && !out_ready.
  - Both saturate at all-ones and clear on reset, not on flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rename_pkg:
  - Parameter defaults.
  - areg_t and preg_t typedefs.
  - rename_lane_t struct {valid, rs1, rs2, rd}.
  - renamed_lane_t struct {valid, p_rs1, p_rs2, p_rd, p_old_rd}.
- Sub-module rename_free_list:
  - Holds the free bitvector, applies alloc/free/flush rebuild.
  - Combinational pick of the WIDTH lowest set bits, plus popcount.

Test Plan:
- Reset, then accept {rd=5, rd=6}, both lanes valid -> out_p_rd = {32, 33}, old_rd = {5, 6}, free_count 32 -> 30, latency 1.
- Group {lane0: rd=3; lane1: rs1=3, rd=3} -> lane1 p_rs1 = 32, p_old_rd = 32, p_rd = 33; spec RAT[3] = 33.
- Exhaust until free_count = 1 -> in_ready = 0. Commit p_old_rd = 7 -> free_count = 2 next cycle, in_ready = 1, next alloc returns p7.
- Hold out_ready = 0 for 3 cycles with a second group pending -> out_* stable, in_ready = 0, nothing lost.
- Rename rd=4 -> p32 and rd=9 -> p33, commit only rd=4, then flush -> spec RAT[9] = 9, RAT[4] = 32, p33 free, p4 free, free_count = 32.
- rd = 0 lanes and commit p_old_rd = 0 -> no allocation, p0 never freed, free_count unchanged.
